// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RISC-V core: sequences fetch/decode/execute/
// memory/write-back, drives datapath strobes and selects, and counts retired instructions.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        pc_source,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  ALUOp,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;

  // The branch decision is taken in the datapath (pc_write_cond & zero), not here.
  logic unused_zero;
  assign unused_zero = zero;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          default:            state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: state_d = S_WB_ALU;
      S_EXEC_I: state_d = S_WB_ALU;
      S_ADDR:   state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_WB_ALU: state_d = S_FETCH;
      S_WB_MEM: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_TRAP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    retire = (state_q == S_WB_ALU) || (state_q == S_WB_MEM) || (state_q == S_BRANCH) ||
             ((state_q == S_MEM_WR) && mem_ready);
    instret_d = instret_q + {31'd0, retire};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Moore decode of the current state; only ir_write/pc_write look at mem_ready.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    ALUOp         = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        ALUOp     = 2'b10;
      end
      S_EXEC_I, S_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b01;
        ALUOp         = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
    // Reset kills every write strobe at once, without waiting for a clock edge.
    if (reset) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
      illegal       = 1'b0;
    end
  end

  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-scenario tasks check state sequences,
// strobes, selects and the retired-instruction counter against hand-computed values.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source;
  logic [1:0]  alu_src_a, alu_src_b, ALUOp;
  logic        reg_write, mem_to_reg, illegal;
  logic [31:0] instret;
  logic [3:0]  state;

  int          n_tests;
  int          n_fail;
  logic [31:0] exp_instret;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp(ALUOp),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .instret(instret), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_ready = 1'b1; opcode = 7'd0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (state !== 4'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", state); end
    n_tests++; if (instret !== 32'd0) begin n_fail++; $display("FAIL rst_instret got %0d exp 0", instret); end
    n_tests++; if ({mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write, illegal} !== 7'd0) begin
      n_fail++; $display("FAIL rst_strobes got %b exp 0000000", {mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write, illegal}); end
    n_tests++; if ({i_or_d, alu_src_a, alu_src_b, ALUOp} !== 7'b0_00_01_00) begin
      n_fail++; $display("FAIL rst_selects got %b exp 0000100", {i_or_d, alu_src_a, alu_src_b, ALUOp}); end
    reset = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b1 || ir_write !== 1'b1) begin
      n_fail++; $display("FAIL first_fetch mem_req=%b ir_write=%b exp 1 1", mem_req, ir_write); end
  endtask

  // Runs add (and a stalled sd interrupted by reset), then add again after reset.
  task automatic test_reset_mid_rtype;
    logic [3:0] seq [0:4];
    seq = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd0};
    opcode = 7'b0110011; mem_ready = 1'b1;
    repeat (4) tick;
    exp_instret = exp_instret + 1;
    n_tests++; if (instret !== exp_instret) begin n_fail++; $display("FAIL pre_add_instret got %0d exp %0d", instret, exp_instret); end
    opcode = 7'b0100011;
    repeat (3) tick;
    mem_ready = 1'b0;
    #1;
    n_tests++; if (state !== 4'd6 || mem_req !== 1'b1 || mem_we !== 1'b1 || i_or_d !== 1'b1) begin
      n_fail++; $display("FAIL memwr_wait state=%0d req=%b we=%b iord=%b exp 6 1 1 1", state, mem_req, mem_we, i_or_d); end
    #1 reset = 1'b1;
    #1;
    n_tests++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || state !== 4'd0 || instret !== 32'd0) begin
      n_fail++; $display("FAIL midrst req=%b we=%b state=%0d instret=%0d exp 0 0 0 0", mem_req, mem_we, state, instret); end
    mem_ready = 1'b1;
    tick;
    n_tests++; if (mem_we !== 1'b0 || reg_write !== 1'b0 || pc_write !== 1'b0) begin
      n_fail++; $display("FAIL held_rst we=%b rw=%b pcw=%b exp 0 0 0", mem_we, reg_write, pc_write); end
    exp_instret = 32'd0;
    reset = 1'b0; opcode = 7'b0110011;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++; if (state !== seq[i]) begin n_fail++; $display("FAIL add_state[%0d] got %0d exp %0d", i, state, seq[i]); end
      n_tests++; if (reg_write !== (seq[i] == 4'd7)) begin n_fail++; $display("FAIL add_regwrite[%0d] got %b", i, reg_write); end
      if (seq[i] == 4'd2) begin
        n_tests++; if (ALUOp !== 2'b10 || alu_src_a !== 2'b01 || alu_src_b !== 2'b00) begin
          n_fail++; $display("FAIL add_exec aluop=%b a=%b b=%b exp 10 01 00", ALUOp, alu_src_a, alu_src_b); end
      end
      if (i < 4) tick;
    end
    exp_instret = exp_instret + 1;
    n_tests++; if (instret !== exp_instret) begin n_fail++; $display("FAIL add_instret got %0d exp %0d", instret, exp_instret); end
  endtask

  task automatic test_ld_wait;
    logic [3:0] seq [0:9];
    logic       mr  [0:9];
    int         irw;
    seq = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd8, 4'd0};
    mr  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    irw = 0;
    opcode = 7'b0000011; zero = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_ready = mr[i];
      #1;
      n_tests++; if (state !== seq[i]) begin n_fail++; $display("FAIL ld_state[%0d] got %0d exp %0d", i, state, seq[i]); end
      if (i < 9 && ir_write === 1'b1) irw++;
      if (seq[i] == 4'd0 && i < 9) begin
        n_tests++; if (mem_req !== 1'b1 || alu_src_b !== 2'b01 || pc_write !== mr[i]) begin
          n_fail++; $display("FAIL ld_fetch[%0d] req=%b b=%b pcw=%b exp 1 01 %b", i, mem_req, alu_src_b, pc_write, mr[i]); end
      end
      if (seq[i] == 4'd1) begin
        n_tests++; if (alu_src_a !== 2'b10 || alu_src_b !== 2'b10 || ALUOp !== 2'b00) begin
          n_fail++; $display("FAIL ld_decode a=%b b=%b aluop=%b exp 10 10 00", alu_src_a, alu_src_b, ALUOp); end
      end
      if (seq[i] == 4'd5) begin
        n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || i_or_d !== 1'b1) begin
          n_fail++; $display("FAIL ld_memrd[%0d] req=%b we=%b iord=%b exp 1 0 1", i, mem_req, mem_we, i_or_d); end
      end
      if (seq[i] == 4'd8) begin
        n_tests++; if (mem_to_reg !== 1'b1 || reg_write !== 1'b1) begin
          n_fail++; $display("FAIL ld_wbmem m2r=%b rw=%b exp 1 1", mem_to_reg, reg_write); end
      end
      if (i < 9) tick;
    end
    n_tests++; if (irw !== 1) begin n_fail++; $display("FAIL ld_irwrite_count got %0d exp 1", irw); end
    exp_instret = exp_instret + 1;
    n_tests++; if (instret !== exp_instret) begin n_fail++; $display("FAIL ld_instret got %0d exp %0d", instret, exp_instret); end
    zero = 1'b0;
  endtask

  task automatic test_beq;
    logic [3:0] seq [0:3];
    seq = '{4'd0, 4'd1, 4'd9, 4'd0};
    opcode = 7'b1100011; mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      for (int i = 0; i < 4; i++) begin
        #1;
        n_tests++; if (state !== seq[i]) begin n_fail++; $display("FAIL beq%0d_state[%0d] got %0d exp %0d", z, i, state, seq[i]); end
        n_tests++; if (pc_write_cond !== (seq[i] == 4'd9)) begin n_fail++; $display("FAIL beq%0d_pwc[%0d] got %b", z, i, pc_write_cond); end
        if (seq[i] == 4'd9) begin
          n_tests++; if (pc_source !== 1'b1 || ALUOp !== 2'b01 || alu_src_a !== 2'b01 || alu_src_b !== 2'b00) begin
            n_fail++; $display("FAIL beq%0d_branch src=%b aluop=%b a=%b b=%b exp 1 01 01 00", z, pc_source, ALUOp, alu_src_a, alu_src_b); end
        end
        if (i < 3) tick;
      end
      exp_instret = exp_instret + 1;
      n_tests++; if (instret !== exp_instret) begin n_fail++; $display("FAIL beq%0d_instret got %0d exp %0d", z, instret, exp_instret); end
    end
    zero = 1'b0;
  endtask

  task automatic test_sd_slli;
    logic [3:0] sseq [0:4];
    logic [3:0] iseq [0:4];
    sseq = '{4'd0, 4'd1, 4'd4, 4'd6, 4'd0};
    iseq = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd0};
    opcode = 7'b0100011; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++; if (state !== sseq[i]) begin n_fail++; $display("FAIL sd_state[%0d] got %0d exp %0d", i, state, sseq[i]); end
      n_tests++; if (mem_we !== (sseq[i] == 4'd6) || reg_write !== 1'b0) begin
        n_fail++; $display("FAIL sd_strobes[%0d] we=%b rw=%b", i, mem_we, reg_write); end
      if (i < 4) tick;
    end
    exp_instret = exp_instret + 1;
    n_tests++; if (instret !== exp_instret) begin n_fail++; $display("FAIL sd_instret got %0d exp %0d", instret, exp_instret); end
    opcode = 7'b0010011;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++; if (state !== iseq[i]) begin n_fail++; $display("FAIL slli_state[%0d] got %0d exp %0d", i, state, iseq[i]); end
      if (iseq[i] == 4'd3) begin
        n_tests++; if (alu_src_b !== 2'b10 || ALUOp !== 2'b00 || alu_src_a !== 2'b01) begin
          n_fail++; $display("FAIL slli_exec b=%b aluop=%b a=%b exp 10 00 01", alu_src_b, ALUOp, alu_src_a); end
      end
      if (i < 4) tick;
    end
    exp_instret = exp_instret + 1;
    n_tests++; if (instret !== exp_instret) begin n_fail++; $display("FAIL slli_instret got %0d exp %0d", instret, exp_instret); end
  endtask

  task automatic test_illegal;
    logic [3:0] seq [0:3];
    int         pulses;
    seq = '{4'd0, 4'd1, 4'd10, 4'd0};
    pulses = 0;
    opcode = 7'b1111111; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (state !== seq[i]) begin n_fail++; $display("FAIL ill_state[%0d] got %0d exp %0d", i, state, seq[i]); end
      if (illegal === 1'b1) pulses++;
      n_tests++; if (reg_write !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL ill_strobes[%0d] rw=%b we=%b", i, reg_write, mem_we); end
      if (i < 3) tick;
    end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL ill_pulse_count got %0d exp 1", pulses); end
    n_tests++; if (instret !== exp_instret) begin n_fail++; $display("FAIL ill_instret got %0d exp %0d", instret, exp_instret); end
  endtask

  task automatic test_wrap;
    opcode = 7'b0110011; mem_ready = 1'b1;
    #1;
    force dut.instret_q = 32'hFFFF_FFFF;
    tick;
    release dut.instret_q;
    #1;
    n_tests++; if (instret !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload got %h exp ffffffff", instret); end
    repeat (3) tick;
    #1;
    n_tests++; if (state !== 4'd0 || instret !== 32'd0) begin
      n_fail++; $display("FAIL wrap state=%0d instret=%h exp 0 00000000", state, instret); end
    exp_instret = 32'd0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; exp_instret = 32'd0;
    reset = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    test_reset;
    test_reset_mid_rtype;
    test_ld_wait;
    test_beq;
    test_sd_slli;
    test_illegal;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
